// File: rtl/line_fill_responder_if.sv
// Bus bundle for line_fill_responder.
// Cache side : cache_read / cache_address in, cache_resp / cache_rdata out (responder view).
// Memory side: burst_read / burst_address out, burst_resp / burst_rdata in (responder view).
// Modports:
//   slave  - the responder (serves cache reads, masters the burst port)
//   master - the environment (prefetch unit issuing reads, memory returning beats)
interface line_fill_responder_if #(
    parameter int unsigned BeatW = 64,
    parameter int unsigned LineW = 256
) ();
    logic             cache_read;
    logic [31:0]      cache_address;
    logic             cache_resp;
    logic [LineW-1:0] cache_rdata;
    logic             burst_read;
    logic [31:0]      burst_address;
    logic             burst_resp;
    logic [BeatW-1:0] burst_rdata;

    modport slave (
        input  cache_read,
        input  cache_address,
        output cache_resp,
        output cache_rdata,
        output burst_read,
        output burst_address,
        input  burst_resp,
        input  burst_rdata
    );

    modport master (
        output cache_read,
        output cache_address,
        input  cache_resp,
        input  cache_rdata,
        input  burst_read,
        input  burst_address,
        output burst_resp,
        output burst_rdata
    );
endinterface

// File: rtl/line_fill_responder.sv
// Fully-associative line-buffer cache responder.
// Hits are answered one cycle after the read is accepted; misses issue a 4-beat burst
// read, install the assembled line round-robin, then respond.
// Ports:
//   clk_i  - clock, rising edge
//   rst_ni - asynchronous active-low reset
//   bus    - line_fill_responder_if.slave (cache request/response + memory burst port)
module line_fill_responder #(
    parameter int unsigned Entries = 2,
    parameter int unsigned BeatW   = 64,
    parameter int unsigned LineW   = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    line_fill_responder_if.slave  bus
);

    localparam int unsigned PtrW = (Entries > 1) ? $clog2(Entries) : 1;
    localparam int unsigned TagW = 27;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StFill = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [Entries-1:0] valid_q, valid_d;
    logic [TagW-1:0]  tag_q [Entries];
    logic [TagW-1:0]  tag_d [Entries];
    logic [LineW-1:0] data_q [Entries];
    logic [LineW-1:0] data_d [Entries];
    logic [PtrW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [1:0]       beat_cnt_q, beat_cnt_d;
    // Beats 0..2 are buffered; beat 3 is taken straight from the bus when the line is built.
    logic [BeatW-1:0] beat_buf_q [3];
    logic [BeatW-1:0] beat_buf_d [3];
    logic [TagW-1:0]  fill_tag_q, fill_tag_d;
    logic [LineW-1:0] rdata_q, rdata_d;

    logic [TagW-1:0]  req_tag;
    logic             hit;
    logic [PtrW-1:0]  hit_idx;
    logic [LineW-1:0] fill_line;
    logic             unused_offset;

    assign req_tag       = bus.cache_address[31:5];
    // Offset bits select a byte within the line and never affect lookup.
    assign unused_offset = ^bus.cache_address[4:0];
    assign fill_line     = {bus.burst_rdata, beat_buf_q[2], beat_buf_q[1], beat_buf_q[0]};

    // Tag lookup; fills only happen on a miss, so at most one entry matches.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < Entries; i++) begin
            if (valid_q[i] && (tag_q[i] == req_tag)) begin
                hit     = 1'b1;
                hit_idx = PtrW'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        tag_d      = tag_q;
        data_d     = data_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        beat_buf_d = beat_buf_q;
        fill_tag_d = fill_tag_q;
        rdata_d    = rdata_q;

        unique case (state_q)
            StIdle: begin
                if (bus.cache_read) begin
                    if (hit) begin
                        rdata_d = data_q[hit_idx];
                        state_d = StResp;
                    end else begin
                        fill_tag_d = req_tag;
                        beat_cnt_d = 2'd0;
                        state_d    = StFill;
                    end
                end
            end
            StFill: begin
                if (bus.burst_resp) begin
                    beat_cnt_d = beat_cnt_q + 2'd1;
                    if (beat_cnt_q == 2'd3) begin
                        valid_d[rr_ptr_q] = 1'b1;
                        tag_d[rr_ptr_q]   = fill_tag_q;
                        data_d[rr_ptr_q]  = fill_line;
                        rr_ptr_d          = rr_ptr_q + PtrW'(1);
                        // A requester that walked away still gets the line installed,
                        // but the visible read data is left untouched.
                        if (bus.cache_read) begin
                            rdata_d = fill_line;
                            state_d = StResp;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        beat_buf_d[beat_cnt_q] = bus.burst_rdata;
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            valid_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            fill_tag_q <= '0;
            rdata_q    <= '0;
            for (int unsigned i = 0; i < Entries; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
            for (int unsigned i = 0; i < 3; i++) begin
                beat_buf_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            fill_tag_q <= fill_tag_d;
            rdata_q    <= rdata_d;
            tag_q      <= tag_d;
            data_q     <= data_d;
            beat_buf_q <= beat_buf_d;
        end
    end

    assign bus.burst_read    = (state_q == StFill);
    assign bus.burst_address = {fill_tag_q, 5'b0};
    assign bus.cache_resp    = (state_q == StResp);
    assign bus.cache_rdata   = rdata_q;

endmodule
